br_tag_ctrl: RTL and testbench

- Branch tag allocator and recovery controller, sitting between dispatch, the branch functional unit and the ROB / fetch redirect path.
- Hands out one-hot branch tags to dispatching branches and tracks which older branches each tag depends on.
- Consumes the branch unit's right/wrong resolution and broadcasts the squash (rob_br_recovery / rob_br_tag_fix), the tag clear, and the fetch redirect that the rest of the pipeline obeys.

---
 rtl/br_tag_ctrl.sv | 103 ++++++++++
 tb/tb_br_tag_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/br_tag_ctrl.sv
// Branch tag allocator and misprediction recovery controller.
// Hands out one-hot tags, tracks per-tag dependencies, and broadcasts clear/squash/redirect.
module br_tag_ctrl #(
    parameter int BR_MASK_W = 4,
    parameter int ROB_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 disp_br_req_i,
    output logic                 disp_br_ready_o,
    output logic [BR_MASK_W-1:0] disp_br_tag_1hot_o,
    output logic [BR_MASK_W-1:0] disp_br_mask_o,
    input  logic                 br_right_i,
    input  logic                 br_wrong_i,
    input  logic [BR_MASK_W-1:0] br_mask_1hot_i,
    input  logic [63:0]          br_recovery_target_i,
    input  logic [ROB_IDX_W:0]   br2rob_recovery_idx_i,
    output logic                 rob_br_recovery_o,
    output logic [BR_MASK_W-1:0] rob_br_tag_fix_o,
    output logic [ROB_IDX_W:0]   rob_recovery_idx_o,
    output logic                 br_clear_o,
    output logic [BR_MASK_W-1:0] br_clear_1hot_o,
    output logic                 fetch_redirect_o,
    output logic [63:0]          fetch_target_o
);

    typedef enum logic [1:0] {NORMAL, RECOVER, DRAIN} state_t;

    state_t               state;
    logic [BR_MASK_W-1:0] valid_r;
    logic [BR_MASK_W-1:0] dep_r [BR_MASK_W];

    logic                 normal, alloc, right_hit, wrong_hit;
    logic [BR_MASK_W-1:0] free_1hot, younger, clr_mask, valid_cleared;

    assign normal         = (state == NORMAL);
    assign free_1hot      = ~valid_r & (valid_r + 1'b1);
    assign disp_br_mask_o = valid_r;
    assign disp_br_tag_1hot_o = free_1hot;
    assign disp_br_ready_o    = (valid_r != '1) && normal;

    // Resolutions of tags that are not outstanding are dropped; wrong beats right.
    assign wrong_hit = normal && br_wrong_i && |(br_mask_1hot_i & valid_r);
    assign right_hit = normal && br_right_i && !br_wrong_i && |(br_mask_1hot_i & valid_r);
    assign alloc     = disp_br_req_i && disp_br_ready_o;

    assign clr_mask      = right_hit ? br_mask_1hot_i : '0;
    assign valid_cleared = valid_r & ~clr_mask;

    always_comb begin
        younger = '0;
        for (int i = 0; i < BR_MASK_W; i++)
            younger[i] = |(dep_r[i] & br_mask_1hot_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= NORMAL;
            valid_r            <= '0;
            for (int i = 0; i < BR_MASK_W; i++) dep_r[i] <= '0;
            rob_br_recovery_o  <= 1'b0;
            rob_br_tag_fix_o   <= '0;
            rob_recovery_idx_o <= '0;
            br_clear_o         <= 1'b0;
            br_clear_1hot_o    <= '0;
            fetch_redirect_o   <= 1'b0;
            fetch_target_o     <= '0;
        end else begin
            rob_br_recovery_o <= 1'b0;
            rob_br_tag_fix_o  <= '0;
            br_clear_o        <= 1'b0;
            br_clear_1hot_o   <= '0;
            fetch_redirect_o  <= 1'b0;
            case (state)
                NORMAL: begin
                    if (wrong_hit) begin
                        // Squash the wrong tag and everything allocated after it; drop any same-cycle grant.
                        valid_r            <= valid_r & ~(br_mask_1hot_i | younger);
                        rob_br_recovery_o  <= 1'b1;
                        rob_br_tag_fix_o   <= br_mask_1hot_i;
                        fetch_redirect_o   <= 1'b1;
                        fetch_target_o     <= br_recovery_target_i;
                        rob_recovery_idx_o <= br2rob_recovery_idx_i;
                        state              <= RECOVER;
                    end else begin
                        valid_r <= valid_cleared | (alloc ? free_1hot : '0);
                        for (int i = 0; i < BR_MASK_W; i++) begin
                            if (alloc && free_1hot[i]) dep_r[i] <= valid_cleared;
                            else                       dep_r[i] <= dep_r[i] & ~clr_mask;
                        end
                        if (right_hit) begin
                            br_clear_o      <= 1'b1;
                            br_clear_1hot_o <= br_mask_1hot_i;
                        end
                    end
                end
                RECOVER: state <= DRAIN;
                default: state <= NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_br_tag_ctrl.sv
// Directed, table-driven bench for br_tag_ctrl with hand-computed expectations.
module tb_br_tag_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        disp_br_req_i = 1'b0;
    logic        disp_br_ready_o;
    logic [3:0]  disp_br_tag_1hot_o, disp_br_mask_o;
    logic        br_right_i = 1'b0, br_wrong_i = 1'b0;
    logic [3:0]  br_mask_1hot_i = '0;
    logic [63:0] br_recovery_target_i = '0;
    logic [5:0]  br2rob_recovery_idx_i = '0;
    logic        rob_br_recovery_o;
    logic [3:0]  rob_br_tag_fix_o;
    logic [5:0]  rob_recovery_idx_o;
    logic        br_clear_o;
    logic [3:0]  br_clear_1hot_o;
    logic        fetch_redirect_o;
    logic [63:0] fetch_target_o;

    br_tag_ctrl #(.BR_MASK_W(4), .ROB_IDX_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_br_req_i(disp_br_req_i), .disp_br_ready_o(disp_br_ready_o),
        .disp_br_tag_1hot_o(disp_br_tag_1hot_o), .disp_br_mask_o(disp_br_mask_o),
        .br_right_i(br_right_i), .br_wrong_i(br_wrong_i), .br_mask_1hot_i(br_mask_1hot_i),
        .br_recovery_target_i(br_recovery_target_i), .br2rob_recovery_idx_i(br2rob_recovery_idx_i),
        .rob_br_recovery_o(rob_br_recovery_o), .rob_br_tag_fix_o(rob_br_tag_fix_o),
        .rob_recovery_idx_o(rob_recovery_idx_o), .br_clear_o(br_clear_o),
        .br_clear_1hot_o(br_clear_1hot_o), .fetch_redirect_o(fetch_redirect_o),
        .fetch_target_o(fetch_target_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req, right, wrong;
        logic [3:0]  mask;
        logic [63:0] tgt;
        logic [5:0]  idx;
        logic        e_ready;
        logic [3:0]  e_tag, e_dmask;
        logic        e_clr;
        logic [3:0]  e_c1h;
        logic        e_rec;
        logic [3:0]  e_fix;
        logic        e_redir;
        logic [63:0] e_tgt;
        logic [5:0]  e_idx;
    } vec_t;

    localparam int NV = 20;
    vec_t vec [NV];
    int errors = 0;
    int checks = 0;

    function automatic logic [89:0] pack_exp(input vec_t v);
        return {v.e_ready, v.e_tag, v.e_dmask, v.e_clr, v.e_c1h, v.e_rec,
                v.e_fix, v.e_redir, v.e_tgt, v.e_idx};
    endfunction

    function automatic logic [89:0] pack_act();
        return {disp_br_ready_o, disp_br_tag_1hot_o, disp_br_mask_o, br_clear_o,
                br_clear_1hot_o, rob_br_recovery_o, rob_br_tag_fix_o, fetch_redirect_o,
                fetch_target_o, rob_recovery_idx_o};
    endfunction

    task automatic check(input string name, input logic [89:0] act, input logic [89:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // req right wrong mask tgt idx | ready tag dmask clr c1h rec fix redir tgt idx
        vec[0]  = '{1,0,0,4'h0,64'h0,6'h00,    1,4'h2,4'h1,0,4'h0,0,4'h0,0,64'h0,6'h00};
        vec[1]  = '{1,0,0,4'h0,64'h0,6'h00,    1,4'h4,4'h3,0,4'h0,0,4'h0,0,64'h0,6'h00};
        vec[2]  = '{1,0,0,4'h0,64'h0,6'h00,    1,4'h8,4'h7,0,4'h0,0,4'h0,0,64'h0,6'h00};
        vec[3]  = '{1,0,0,4'h0,64'h0,6'h00,    0,4'h0,4'hF,0,4'h0,0,4'h0,0,64'h0,6'h00};
        vec[4]  = '{1,0,0,4'h0,64'h0,6'h00,    0,4'h0,4'hF,0,4'h0,0,4'h0,0,64'h0,6'h00};
        vec[5]  = '{0,1,0,4'h2,64'h0,6'h00,    1,4'h2,4'hD,1,4'h2,0,4'h0,0,64'h0,6'h00};
        vec[6]  = '{0,0,0,4'h0,64'h0,6'h00,    1,4'h2,4'hD,0,4'h0,0,4'h0,0,64'h0,6'h00};
        vec[7]  = '{0,0,1,4'h4,64'h1000,6'h05, 0,4'h2,4'h1,0,4'h0,1,4'h4,1,64'h1000,6'h05};
        vec[8]  = '{0,1,0,4'h1,64'h0,6'h00,    0,4'h2,4'h1,0,4'h0,0,4'h0,0,64'h1000,6'h05};
        vec[9]  = '{0,0,1,4'h1,64'h9999,6'h09, 1,4'h2,4'h1,0,4'h0,0,4'h0,0,64'h1000,6'h05};
        vec[10] = '{1,1,1,4'h1,64'h2000,6'h21, 0,4'h1,4'h0,0,4'h0,1,4'h1,1,64'h2000,6'h21};
        vec[11] = '{0,0,0,4'h0,64'h0,6'h00,    0,4'h1,4'h0,0,4'h0,0,4'h0,0,64'h2000,6'h21};
        vec[12] = '{0,0,0,4'h0,64'h0,6'h00,    1,4'h1,4'h0,0,4'h0,0,4'h0,0,64'h2000,6'h21};
        vec[13] = '{1,0,0,4'h0,64'h0,6'h00,    1,4'h2,4'h1,0,4'h0,0,4'h0,0,64'h2000,6'h21};
        vec[14] = '{1,1,0,4'h1,64'h0,6'h00,    1,4'h1,4'h2,1,4'h1,0,4'h0,0,64'h2000,6'h21};
        vec[15] = '{0,0,1,4'h1,64'h5555,6'h03, 1,4'h1,4'h2,0,4'h0,0,4'h0,0,64'h2000,6'h21};
        vec[16] = '{1,0,0,4'h0,64'h0,6'h00,    1,4'h4,4'h3,0,4'h0,0,4'h0,0,64'h2000,6'h21};
        vec[17] = '{0,0,1,4'h1,64'h3000,6'h0A, 0,4'h1,4'h2,0,4'h0,1,4'h1,1,64'h3000,6'h0A};
        vec[18] = '{0,0,0,4'h0,64'h0,6'h00,    0,4'h1,4'h2,0,4'h0,0,4'h0,0,64'h3000,6'h0A};
        vec[19] = '{0,0,0,4'h0,64'h0,6'h00,    1,4'h1,4'h2,0,4'h0,0,4'h0,0,64'h3000,6'h0A};

        #12;
        check("reset_state", pack_act(), {1'b1, 4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 64'h0, 6'h0});
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            disp_br_req_i         = vec[i].req;
            br_right_i            = vec[i].right;
            br_wrong_i            = vec[i].wrong;
            br_mask_1hot_i        = vec[i].mask;
            br_recovery_target_i  = vec[i].tgt;
            br2rob_recovery_idx_i = vec[i].idx;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), pack_act(), pack_exp(vec[i]));
        end

        // Reset asserted while the squash pulse is out: everything returns to reset state at once.
        disp_br_req_i = 1'b0; br_right_i = 1'b0; br_wrong_i = 1'b1;
        br_mask_1hot_i = 4'h2; br_recovery_target_i = 64'h4000; br2rob_recovery_idx_i = 6'h07;
        @(posedge clk); #1;
        br_wrong_i = 1'b0;
        check("pre_reset_recover", pack_act(), {1'b0, 4'h1, 4'h0, 1'b0, 4'h0, 1'b1, 4'h2, 1'b1, 64'h4000, 6'h07});
        #1 rst_n = 1'b0;
        #1;
        check("reset_mid_recover", pack_act(), {1'b1, 4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 64'h0, 6'h0});
        @(posedge clk); #1;
        check("reset_held", pack_act(), {1'b1, 4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 64'h0, 6'h0});
        @(negedge clk) rst_n = 1'b1;
        disp_br_req_i = 1'b1;
        @(posedge clk); #1;
        disp_br_req_i = 1'b0;
        check("alloc_after_reset", pack_act(), {1'b1, 4'h2, 4'h1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 64'h0, 6'h0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
